fir_ref: RTL and testbench
==========================

FIR_REF -- requirements
Module: fir_ref

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed sample width of data_in and data_out.
REQ-002 Parameter COEFF_WIDTH, default 8: signed width of each coefficient.
REQ-003 Parameter NUM_TAPS, default 4, legal range 1..64: number of filter taps.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 data_in  input  DATA_WIDTH: signed two's-complement sample, sampled every rising clk edge.
REQ-007 packed_coeff  input  COEFF_WIDTH*NUM_TAPS: signed coefficients c[k] at bits [(k+1)*COEFF_WIDTH-1 : k*COEFF_WIDTH]; c[0] in the LSBs.
REQ-008 data_out  output  DATA_WIDTH: signed filtered sample, registered.

Function
REQ-009 The block SHALL be a direct-form FIR; no valid/ready handshake; one new input accepted every clock cycle.
REQ-010 The delay line SHALL hold NUM_TAPS-1 past samples x[1]..x[NUM_TAPS-1]; each edge x[1]<=data_in, x[k]<=x[k-1].
REQ-011 At each rising edge n, data_out SHALL load y(n) = sum over k=0..NUM_TAPS-1 of c[k]*x(n-k), where x(n) is data_in at edge n. Latency: 1 cycle from data_in to its first contribution on data_out.
REQ-012 Products SHALL be full-precision signed (DATA_WIDTH+COEFF_WIDTH bits).
REQ-013 The accumulator SHALL be DATA_WIDTH+COEFF_WIDTH+ceil(log2(NUM_TAPS)) bits signed and SHALL never overflow internally.
REQ-014 No scaling or shifting SHALL be applied; the accumulator is reduced to DATA_WIDTH per REQ-020/REQ-021.
REQ-015 packed_coeff SHALL be used combinationally; a change takes effect at the next rising edge, with no coefficient register.
REQ-016 Samples taken before the most recent reset release SHALL never contribute to data_out.

Reset
REQ-017 When rst_n is low, data_out SHALL be 0 and every delay-line register SHALL be 0, immediately and without a clock edge.
REQ-018 Reset asserted mid-stream SHALL discard all history.
REQ-019 The first rising edge after rst_n rises SHALL compute y using data_in and zero history.

Configuration
REQ-020 With macro FIR_REF_SAT_EN defined, data_out SHALL saturate the accumulator to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-021 Without FIR_REF_SAT_EN, data_out SHALL be the low DATA_WIDTH bits of the accumulator, two's-complement wrap.
REQ-022 Results that do not overflow SHALL be identical in both builds.

Verification
(All scenarios use DATA_WIDTH=16, COEFF_WIDTH=8, NUM_TAPS=4 unless stated.)
REQ-023 Coeffs {c3,c2,c1,c0}={4,3,-1,-2}; data_in=1 for one cycle, then 0 -> data_out on successive edges = -2,-1,3,4,0,0.
REQ-024 Same coeffs, from zero history; data_in=-3,1,0,-2 on successive edges -> data_out = 6,1,-10,-5.
REQ-025 Same coeffs; data_in=0 for 4 cycles after reset -> data_out stays 0.
REQ-026 All coeffs 127, data_in held at 32767 -> from 4th edge, data_out = 32767 with FIR_REF_SAT_EN, -508 without.
REQ-027 All coeffs -128, data_in held at -32768 -> with FIR_REF_SAT_EN, saturates to 32767 from the 1st edge.
REQ-028 Reset mid-stream -> data_out 0 asynchronously. After release, data_in=1 then 0 (coeffs of REQ-023) -> -2,-1,3,4 with no residue from before reset.

Source files
------------

// File: rtl/fir_ref.sv
// Direct-form FIR filter: one sample per clock, registered output.
// Optional build macro FIR_REF_SAT_EN saturates the output instead of wrapping.
module fir_ref #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeff,
  output logic [DATA_WIDTH-1:0]           data_out
);

  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int AW = PW + $clog2(NUM_TAPS);

  logic signed [DATA_WIDTH-1:0] taps [NUM_TAPS];
  logic signed [AW-1:0]         acc_d;
  logic [DATA_WIDTH-1:0]        y_d;
  logic [DATA_WIDTH-1:0]        y_q;

  assign taps[0] = $signed(data_in);

  generate
    if (NUM_TAPS > 1) begin : g_delay
      // x_q[i] holds the sample seen i+1 edges ago
      logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_TAPS - 1; i++) begin
            x_q[i] <= '0;
          end
        end else begin
          x_q[0] <= $signed(data_in);
          for (int i = 1; i < NUM_TAPS - 1; i++) begin
            x_q[i] <= x_q[i-1];
          end
        end
      end

      for (genvar k = 1; k < NUM_TAPS; k++) begin : g_tap
        assign taps[k] = x_q[k-1];
      end
    end
  endgenerate

  always_comb begin
    acc_d = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc_d = acc_d + AW'(PW'(taps[k]) *
                          PW'($signed(packed_coeff[k*COEFF_WIDTH +: COEFF_WIDTH])));
    end
  end

`ifdef FIR_REF_SAT_EN
  // Out of range whenever the bits above the output sign bit disagree with it
  always_comb begin
    y_d = acc_d[DATA_WIDTH-1:0];
    if (!acc_d[AW-1] && (|acc_d[AW-2:DATA_WIDTH-1])) begin
      y_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (acc_d[AW-1] && !(&acc_d[AW-2:DATA_WIDTH-1])) begin
      y_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_d[AW-1:DATA_WIDTH];
  assign y_d = acc_d[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign data_out = y_q;

endmodule

// File: tb/tb_fir_ref.sv
// Self-checking bench for fir_ref: directed scenarios plus randomized traffic
// compared against a sum-of-products model over a sample history queue.
module tb_fir_ref;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NT = 4;

  logic                 clk;
  logic                 rstN;
  logic [DW-1:0]        dataIn;
  logic [CW*NT-1:0]     packedCoeff;
  logic signed [DW-1:0] dataOut;

  int testCount;
  int failCount;
  int coeffs [NT];
  int hist [$];
  logic signed [DW-1:0] expVal;

  fir_ref #(
    .DATA_WIDTH (DW),
    .COEFF_WIDTH(CW),
    .NUM_TAPS   (NT)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .data_in     (dataIn),
    .packed_coeff(packedCoeff),
    .data_out    (dataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic setCoeffs(input int c0, input int c1, input int c2, input int c3);
    logic [CW-1:0] b;
    coeffs[0] = c0; coeffs[1] = c1; coeffs[2] = c2; coeffs[3] = c3;
    for (int k = 0; k < NT; k++) begin
      b = coeffs[k][CW-1:0];
      packedCoeff[k*CW +: CW] = b;
    end
  endtask

  task automatic setRandomCoeffs();
    logic signed [CW-1:0] r [NT];
    for (int k = 0; k < NT; k++) r[k] = $urandom;
    setCoeffs(r[0], r[1], r[2], r[3]);
  endtask

  // y(n) = sum c[k]*x(n-k), with missing history treated as zero
  function automatic logic signed [DW-1:0] modelEdge(input int din);
    longint acc;
    longint x;
    logic [63:0] accBits;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      if (k == 0) x = din;
      else if (k - 1 < hist.size()) x = hist[k-1];
      else x = 0;
      acc += longint'(coeffs[k]) * x;
    end
    hist.push_front(din);
    if (hist.size() > NT - 1) void'(hist.pop_back());
`ifdef FIR_REF_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    accBits = acc;
    return accBits[DW-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic signed [DW-1:0] expected);
    testCount++;
    assert (dataOut === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, dataOut, expected);
    end
  endtask

  // Drive one sample, clock it in, and compare against the model
  task automatic applyStimulus(input int din, input string tag);
    logic [31:0] dBits;
    dBits = din;
    dataIn = dBits[DW-1:0];
    @(posedge clk);
    expVal = modelEdge(din);
    #1;
    checkOutput(tag, expVal);
  endtask

  // Called at posedge+1; asserts reset between edges and releases before the next one
  task automatic resetDut(input string tag);
    #1 rstN = 1'b0;
    #2;
    checkOutput(tag, 16'sd0);
    hist.delete();
    #3 rstN = 1'b1;
  endtask

  int dirExp [6];
  int randDin;

  initial begin
    testCount = 0;
    failCount = 0;
    rstN = 1'b0;
    dataIn = '0;
    setCoeffs(-2, -1, 3, 4);
    #2;
    checkOutput("reset_state", 16'sd0);
    @(posedge clk);
    #1;
    resetDut("reset_hold");

    // Zero input keeps the output at zero
    for (int i = 0; i < 4; i++) applyStimulus(0, "zero_in");

    // Impulse response reads the coefficients back in order
    dirExp = '{-2, -1, 3, 4, 0, 0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i == 0) ? 1 : 0, "impulse_model");
      checkOutput("impulse_const", 16'(dirExp[i]));
    end

    resetDut("reset_pre_seq");
    dirExp = '{6, 1, -10, -5, 0, 0};
    begin
      int seq [4];
      seq = '{-3, 1, 0, -2};
      for (int i = 0; i < 4; i++) begin
        applyStimulus(seq[i], "seq_model");
        checkOutput("seq_const", 16'(dirExp[i]));
      end
    end

    // Mid-stream reset then impulse: no residue from the earlier samples
    applyStimulus(1234, "pre_reset_a");
    applyStimulus(-777, "pre_reset_b");
    resetDut("reset_midstream");
    dirExp = '{-2, -1, 3, 4, 0, 0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i == 0) ? 1 : 0, "post_reset_model");
      checkOutput("post_reset_const", 16'(dirExp[i]));
    end

    // Positive overflow
    setCoeffs(127, 127, 127, 127);
    resetDut("reset_pos_ovf");
    for (int i = 0; i < 6; i++) applyStimulus(32767, "pos_ovf_model");
`ifdef FIR_REF_SAT_EN
    checkOutput("pos_ovf_const", 16'sd32767);
`else
    checkOutput("pos_ovf_const", -16'sd508);
`endif

    // Negative extremes multiply to a large positive sum
    setCoeffs(-128, -128, -128, -128);
    resetDut("reset_neg_ovf");
    applyStimulus(-32768, "neg_ovf_first");
`ifdef FIR_REF_SAT_EN
    checkOutput("neg_ovf_first_const", 16'sd32767);
`else
    checkOutput("neg_ovf_first_const", 16'sd0);
`endif
    for (int i = 0; i < 4; i++) applyStimulus(-32768, "neg_ovf_model");

    // Random traffic with coefficient changes, extremes and occasional resets
    setRandomCoeffs();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) setRandomCoeffs();
      case ($urandom_range(0, 9))
        0: randDin = 32767;
        1: randDin = -32768;
        default: begin
          logic signed [DW-1:0] r;
          r = $urandom;
          randDin = r;
        end
      endcase
      applyStimulus(randDin, "random");
      if ($urandom_range(0, 49) == 0) resetDut("random_reset");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
